// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-outstanding memory port between fetch and load/store
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_state_nxt;
    logic   r_owner, r_last, r_err;
    logic   w_owner_nxt, w_last_nxt, w_err_nxt;
    logic   w_sel, w_idle, w_busy, w_accept;
    // owner/last/sel encoding: 0 = fetch, 1 = data; a tie goes to whoever was not served last
    assign w_sel    = (i_req & d_req) ? ~r_last : d_req;
    assign w_idle   = (r_state == IDLE) & ~rst;
    assign w_busy   = (r_state == BUSY) & ~rst;
    assign w_accept = m_req & m_gnt;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign err      = r_err;
    // State and arbitration history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end
    // Request muxing, grant/response routing and next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        m_req       = w_idle & (i_req | d_req);
        m_we        = w_sel & d_we;
        m_addr      = w_sel ? d_addr : i_addr;
        m_wdata     = w_sel ? d_wdata : '0;
        m_wstrb     = w_sel ? d_wstrb : '0;
        i_gnt       = w_accept & ~w_sel;
        d_gnt       = w_accept & w_sel;
        i_rvalid    = w_busy & m_rvalid & ~r_owner;
        d_rvalid    = w_busy & m_rvalid & r_owner;
        if (r_state == IDLE) begin
            if (w_accept) begin
                w_state_nxt = BUSY;
                w_owner_nxt = w_sel;
                w_last_nxt  = w_sel;
            end
            if (m_rvalid) w_err_nxt = 1'b1;
        end else if (m_rvalid) begin
            w_state_nxt = IDLE;
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: randomized scoreboard bench for mem_arb against a transaction-level arbitration model
module tb_mem_arb;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 0, d_req = 0, d_we = 0, m_gnt = 0, m_rvalid = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [3:0]  d_wstrb = 0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    mem_arb dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {logic d; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} gnt_t;
    typedef struct {logic d; logic chk; logic [31:0] data;} rsp_t;
    gnt_t gq[$];
    rsp_t rq[$];
    int   n_vec = 0, n_err = 0;

    // Reference model: requester phases (0 free, 1 asking, 2 waiting response), memory occupancy, round-robin history
    bit          busy = 0, last = 1, owner = 0, resp_chk = 0;
    int          cnt = 0, i_st = 0, d_st = 0;
    logic [31:0] rdat = 0, resp_data = 0, ni_addr = 0, nd_addr = 0, nd_wdata = 0;
    logic        nd_we = 0;
    logic [3:0]  nd_wstrb = 0;

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", n, a, e);
        end
    endtask

    task automatic rnd_payload();
        ni_addr  = $urandom;
        nd_addr  = $urandom;
        nd_wdata = $urandom;
        nd_we    = 1'($urandom % 2);
        nd_wstrb = 4'($urandom);
        rdat     = $urandom;
    endtask

    // One clock of stimulus; the model decides grants and responses from its own state
    task automatic step(input bit ni, input bit nd, input bit mg, input bit spur, input int lat);
        bit   wb;
        gnt_t g;
        @(posedge clk); #1;
        wb = busy;
        if (i_st == 0 && ni) begin i_st = 1; i_addr = ni_addr; end
        if (d_st == 0 && nd) begin
            d_st = 1; d_addr = nd_addr; d_we = nd_we; d_wdata = nd_wdata; d_wstrb = nd_wstrb;
        end
        i_req    = (i_st == 1);
        d_req    = (d_st == 1);
        m_rvalid = 0;
        m_rdata  = $urandom;
        if (wb) begin
            cnt--;
            if (cnt == 0) begin
                m_rvalid = 1;
                m_rdata  = resp_data;
                rq.push_back('{owner, resp_chk, resp_data});
                busy = 0;
                if (owner) d_st = 0; else i_st = 0;
            end
        end
        if (spur && !wb) m_rvalid = 1;
        m_gnt = mg;
        if (!wb && (i_req || d_req) && mg) begin
            g.d     = (i_req && d_req) ? !last : d_req;
            g.we    = g.d & d_we;
            g.addr  = g.d ? d_addr : i_addr;
            g.wdata = g.d ? d_wdata : 32'h0;
            g.wstrb = g.d ? d_wstrb : 4'h0;
            gq.push_back(g);
            busy = 1; owner = g.d; last = g.d; cnt = lat;
            resp_data = rdat; resp_chk = !g.we;
            if (g.d) d_st = 2; else i_st = 2;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (busy || i_st != 0 || d_st != 0); k++) step(0, 0, 1, 0, 1);
        if (busy || i_st != 0 || d_st != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got busy=%0d i_st=%0d d_st=%0d required idle", busy, i_st, d_st);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or a response
    gnt_t mg_e;
    rsp_t mr_e;
    always @(negedge clk) if (!rst) begin
        if (i_gnt || d_gnt) begin
            if (gq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_gnt: got i_gnt=%b d_gnt=%b required none", i_gnt, d_gnt);
            end else begin
                mg_e = gq.pop_front();
                check("gnt_port", {i_gnt, d_gnt}, {!mg_e.d, mg_e.d});
                check("m_req", m_req, 1);
                check("m_we", m_we, mg_e.we);
                check("m_addr", m_addr, mg_e.addr);
                check("m_wdata", m_wdata, mg_e.wdata);
                check("m_wstrb", m_wstrb, mg_e.wstrb);
            end
        end
        if (gq.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL missed_gnt: got none required %s grant", gq[0].d ? "data" : "fetch");
            gq.delete();
        end
        if (i_rvalid || d_rvalid) begin
            if (rq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_rvalid: got i_rvalid=%b d_rvalid=%b required none", i_rvalid, d_rvalid);
            end else begin
                mr_e = rq.pop_front();
                check("rvalid_port", {i_rvalid, d_rvalid}, {!mr_e.d, mr_e.d});
                if (mr_e.chk) check("rdata", mr_e.d ? d_rdata : i_rdata, mr_e.data);
            end
        end
        if (rq.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL missed_rvalid: got none required %s response", rq[0].d ? "data" : "fetch");
            rq.delete();
        end
    end

    initial begin
        #3;
        i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1;
        #1;
        check("rst_outputs", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        check("rst_err", err, 0);
        i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
        @(posedge clk); #1; rst = 0;
        // single fetch, one-cycle memory
        ni_addr = 32'h100; rdat = 32'h00500093;
        step(1, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        check("err_after_fetch", err, 0);
        // store with three-cycle memory delay
        nd_addr = 32'h2004; nd_we = 1; nd_wdata = 32'hDEADBEEF; nd_wstrb = 4'hF;
        step(0, 1, 1, 0, 3);
        repeat (3) step(0, 0, 1, 0, 1);
        // sustained contention: alternation starts with fetch since data was served last
        repeat (12) begin rnd_payload(); step(1, 1, 1, 0, 1); end
        drain();
        // backpressure, then fetch joins while data waits
        rnd_payload();
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 2);
        drain();
        // response with nothing outstanding is a sticky protocol error
        step(0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 1);
        check("err_set", err, 1);
        rnd_payload();
        step(1, 0, 1, 0, 2);
        drain();
        check("err_sticky", err, 1);
        // reset in the middle of a data transaction
        rnd_payload(); nd_we = 0;
        step(0, 1, 1, 0, 6);
        step(0, 0, 1, 0, 1);
        #2;
        i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1; rst = 1;
        #1;
        check("midrst_outputs", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        check("midrst_err", err, 0);
        busy = 0; last = 1; cnt = 0; i_st = 0; d_st = 0;
        gq.delete(); rq.delete();
        @(posedge clk); #1;
        rst = 0; i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
        check("post_rst_err", err, 0);
        rnd_payload();
        step(1, 1, 1, 0, 1);
        drain();
        // randomized traffic
        repeat (400) begin
            rnd_payload();
            step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) != 0, 0, int'($urandom_range(1, 4)));
        end
        drain();
        check("err_random", err, 0);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
